enc8to3_drain: RTL and testbench

- Sequential 8-to-3 priority encoder; the inverse of the team's 3-to-8 decoder.
- Captures an 8-bit multi-hot request vector. Emits the 3-bit index of every set bit, one per output handshake, highest index first.
- Sits between request-collection logic and any consumer that drives a 3-to-8 decoder with the returned code.

---
 rtl/enc8to3_drain.sv | 76 +++++++
 tb/tb_enc8to3_drain.sv | 131 +++++++++++++
 2 files changed

// File: rtl/enc8to3_drain.sv
// enc8to3_drain: captures a multi-hot 8-bit request vector and returns each set index, highest first, one per handshake.
// Optional out_last_o marker enabled with ENC8TO3_LAST_EN.
module enc8to3_drain (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic [7:0] in_vec_i,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic [2:0] out_code_o,
    output logic       out_none_o
`ifdef ENC8TO3_LAST_EN
    ,
    output logic       out_last_o
`endif
);
    typedef enum logic {IDLE, DRAIN} state_t;
    state_t      state_q;
    logic [7:0]  pending_q, pending_d;
    logic        out_valid_q, out_none_q, fire;
    logic [2:0]  out_code_q;
    function automatic logic [2:0] msb8(input logic [7:0] v);
        msb8 = '0;
        for (int i = 0; i < 8; i++) if (v[i]) msb8 = 3'(i);
    endfunction
`ifdef ENC8TO3_LAST_EN
    logic last_q;
    function automatic logic one_left(input logic [7:0] v);
        return (v & (v - 8'd1)) == 8'd0;
    endfunction
    assign out_last_o = last_q;
`endif
    assign fire        = out_valid_q & out_ready_i;
    assign pending_d   = pending_q & ~(8'd1 << out_code_q);
    // reset must pull in_ready low asynchronously, not just via state
    assign in_ready_o  = rst_n & en_i & (state_q == IDLE);
    assign out_valid_o = out_valid_q;
    assign out_code_o  = out_code_q;
    assign out_none_o  = out_none_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_code_q  <= '0;
            out_none_q  <= 1'b0;
`ifdef ENC8TO3_LAST_EN
            last_q      <= 1'b0;
`endif
        end else if (state_q == IDLE) begin
            if (in_valid_i && in_ready_o) begin
                state_q     <= DRAIN;
                pending_q   <= in_vec_i;
                out_valid_q <= 1'b1;
                out_code_q  <= msb8(in_vec_i);
                out_none_q  <= in_vec_i == 8'd0;
`ifdef ENC8TO3_LAST_EN
                last_q      <= one_left(in_vec_i);
`endif
            end
        end else if (fire) begin
            pending_q  <= pending_d;
            out_none_q <= 1'b0;
            out_code_q <= msb8(pending_d);
            if (pending_d == 8'd0) begin
                state_q     <= IDLE;
                out_valid_q <= 1'b0;
            end
`ifdef ENC8TO3_LAST_EN
            last_q <= (pending_d != 8'd0) && one_left(pending_d);
`endif
        end
    end
endmodule

// File: tb/tb_enc8to3_drain.sv
// tb_enc8to3_drain: directed stimulus against a queue model of expected beats, plus literal spot checks.
module tb_enc8to3_drain;
    logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] in_vec = '0;
    logic       in_ready, out_valid, out_none;
    logic [2:0] out_code;
`ifdef ENC8TO3_LAST_EN
    logic       out_last;
`endif
    int checks = 0, passed = 0;
    int q[$];

    enc8to3_drain dut (
        .clk(clk), .rst_n(rst_n), .en_i(en), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_vec_i(in_vec), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_code_o(out_code), .out_none_o(out_none)
`ifdef ENC8TO3_LAST_EN
        , .out_last_o(out_last)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: a queue of beats still owed; 8 stands for the all-zero "none" beat.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) q.delete();
        else if (q.size() > 0) begin
            if (out_ready) void'(q.pop_front());
        end else if (en && in_valid) begin
            if (in_vec == 8'd0) q.push_back(8);
            else for (int i = 7; i >= 0; i--) if (in_vec[i]) q.push_back(i);
        end
    end

    always @(negedge clk) if (rst_n) begin
        chk("in_ready", int'(in_ready), int'(q.size() == 0 && en));
        chk("out_valid", int'(out_valid), int'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_code", int'(out_code), q[0] % 8);
            chk("out_none", int'(out_none), int'(q[0] == 8));
`ifdef ENC8TO3_LAST_EN
            chk("out_last", int'(out_last), int'(q.size() == 1));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (q.size() > 0 && n < 100) begin step(); n++; end
        chk(name, int'(q.size() == 0), 1);
    endtask

    initial begin
        logic [7:0] a5 = 8'b1010_0101;
        step(); step();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        rst_n = 1'b1; en = 1'b1;
        step();
        chk("post_rst_in_ready", int'(in_ready), 1);
        en = 1'b0; in_valid = 1'b1; in_vec = 8'h10;
        repeat (3) step();
        chk("en0_no_accept", int'(out_valid), 0);
        chk("en0_in_ready", int'(in_ready), 0);
        en = 1'b1; in_vec = a5; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        #1 chk("a5_code0", int'(out_code), 7);
        step(); #1 chk("a5_code1", int'(out_code), 5);
        step(); #1 chk("a5_code2", int'(out_code), 2);
        step(); #1 chk("a5_code3", int'(out_code), 0);
        chk("a5_last_valid", int'(out_valid), 1);
        step(); #1 chk("a5_done_valid", int'(out_valid), 0);
        chk("a5_done_ready", int'(in_ready), 1);
        in_valid = 1'b1; in_vec = 8'h00;
        step();
        in_valid = 1'b0;
        #1 chk("zero_none", int'(out_none), 1);
        chk("zero_code", int'(out_code), 0);
        step(); #1 chk("zero_done", int'(out_valid), 0);
        in_valid = 1'b1; in_vec = 8'hFF; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            out_ready = (i % 3) == 0;
            if (i == 5) en = 1'b0;
            step();
        end
        out_ready = 1'b1;
        wait_idle("ff_drain_timeout");
        en = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            logic [7:0] dec;
            in_vec = 8'd1 << i; in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            dec = 8'd1 << out_code;
            #1 chk("onehot_code", int'(out_code), i);
            chk("onehot_decode", int'(dec), int'(in_vec));
            step();
            chk("onehot_single", int'(out_valid), 0);
        end
        in_vec = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
        step(); in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1 chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_code", int'(out_code), 0);
        chk("midrst_ready", int'(in_ready), 0);
        step();
        rst_n = 1'b1;
        step();
        #1 chk("after_rst_valid", int'(out_valid), 0);
        chk("after_rst_ready", int'(in_ready), 1);
        step(); step();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
